// File: rtl/divisor_clock_prog.sv
// Programmable synchronous clock divider for the irrigation controller timebase.
// Produces a one-cycle tick enable and a registered square wave whose period is
// the active divide ratio; ratio changes wait for the next period boundary.
//
// Ports:
//   clock          - system clock, all logic on rising edge
//   reset          - synchronous active-high reset
//   enable         - count enable
//   sync_clr       - synchronous restart of the current period
//   div_value      - requested divide ratio N (0 is treated as 1)
//   div_load       - capture div_value as the pending ratio
//   div_busy       - a pending ratio is waiting to be applied
//   tick           - one-cycle pulse once per N enabled cycles
//   clock_Reduzido - registered square wave, ceil(N/2) high / floor(N/2) low
//   count          - current phase counter
module divisor_clock_prog #(
    parameter int unsigned WIDTH     = 23,
    parameter int unsigned DIV_RESET = 4194304
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] div_value,
    input  logic             div_load,
    output logic             div_busy,
    output logic             tick,
    output logic             clock_Reduzido,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIV_INIT  = WIDTH'(DIV_RESET);

    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;

    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] div_act_nxt;
    logic [WIDTH-1:0] div_pend_nxt;
    logic [WIDTH-1:0] high_len_nxt;
    logic             div_busy_nxt;
    logic             tick_nxt;
    logic             wrap;

    // Wrap happens on the last count of an enabled period
    assign wrap = enable && !sync_clr && (count == (div_act - ONE));

    // Next-state decode for counter, ratio registers and outputs
    always_comb begin
        count_nxt    = count;
        div_act_nxt  = div_act;
        div_pend_nxt = div_pend;
        div_busy_nxt = div_busy;
        tick_nxt     = 1'b0;

        if (sync_clr) begin
            count_nxt = '0;
            if (div_busy) begin
                div_act_nxt  = div_pend;
                div_busy_nxt = 1'b0;
            end
        end else if (wrap) begin
            count_nxt = '0;
            tick_nxt  = 1'b1;
            if (div_busy) begin
                div_act_nxt  = div_pend;
                div_busy_nxt = 1'b0;
            end
        end else if (enable) begin
            count_nxt = count + ONE;
        end

        // A load lands after any apply, so a coincident load stays pending
        if (div_load) begin
            div_pend_nxt = (div_value == '0) ? ONE : div_value;
            div_busy_nxt = 1'b1;
        end

        // High phase length ceil(N/2), computed without overflow
        high_len_nxt = {1'b0, div_act_nxt[WIDTH-1:1]} + WIDTH'(div_act_nxt[0]);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            count          <= '0;
            div_act        <= DIV_INIT;
            div_pend       <= DIV_INIT;
            div_busy       <= 1'b0;
            tick           <= 1'b0;
            clock_Reduzido <= 1'b1;
        end else begin
            count          <= count_nxt;
            div_act        <= div_act_nxt;
            div_pend       <= div_pend_nxt;
            div_busy       <= div_busy_nxt;
            tick           <= tick_nxt;
            clock_Reduzido <= (count_nxt < high_len_nxt);
        end
    end

endmodule

// File: tb/tb_divisor_clock_prog.sv
// Directed bench for divisor_clock_prog with DIV_RESET=6.
module tb_divisor_clock_prog;

    localparam int unsigned WIDTH = 8;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             sync_clr;
    logic [WIDTH-1:0] div_value;
    logic             div_load;
    logic             div_busy;
    logic             tick;
    logic             clock_Reduzido;
    logic [WIDTH-1:0] count;

    int checks = 0;
    int errors = 0;

    divisor_clock_prog #(
        .WIDTH     (WIDTH),
        .DIV_RESET (6)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .sync_clr       (sync_clr),
        .div_value      (div_value),
        .div_load       (div_load),
        .div_busy       (div_busy),
        .tick           (tick),
        .clock_Reduzido (clock_Reduzido),
        .count          (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic             rst;
        logic             en;
        logic             clr;
        logic             ld;
        logic [WIDTH-1:0] val;
        logic [WIDTH-1:0] exp_cnt;
        logic             exp_tick;
        logic             exp_clk;
        logic             exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic en, input logic clr,
                                input logic ld, input int val, input int cnt,
                                input logic tk, input logic ck, input logic bz);
        vec_t v;
        v.rst      = rst;
        v.en       = en;
        v.clr      = clr;
        v.ld       = ld;
        v.val      = WIDTH'(val);
        v.exp_cnt  = WIDTH'(cnt);
        v.exp_tick = tk;
        v.exp_clk  = ck;
        v.exp_busy = bz;
        return v;
    endfunction

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic step(input string name, input logic rst, input logic en,
                        input logic clr, input logic ld, input int val,
                        input int cnt, input logic tk, input logic ck, input logic bz);
        reset     = rst;
        enable    = en;
        sync_clr  = clr;
        div_load  = ld;
        div_value = WIDTH'(val);
        @(posedge clock);
        #1;
        checks++;
        if (count !== WIDTH'(cnt) || tick !== tk || clock_Reduzido !== ck || div_busy !== bz) begin
            errors++;
            $display("FAIL %s: got count=%0d tick=%b clk=%b busy=%b, want count=%0d tick=%b clk=%b busy=%b",
                     name, count, tick, clock_Reduzido, div_busy, cnt, tk, ck, bz);
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        sync_clr  = 1'b0;
        div_load  = 1'b0;
        div_value = '0;

        // Reset defaults then N=6 counting
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 0));
        // Load N=4, old period of 6 completes first
        vecs.push_back(mk(0, 1, 0, 1, 4, 2, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 5, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0));
        for (int p = 0; p < 2; p++) begin
            vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 0));
            vecs.push_back(mk(0, 1, 0, 0, 0, 2, 0, 0, 0));
            vecs.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 0));
            vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0));
        end
        // Load odd N=5
        vecs.push_back(mk(0, 1, 0, 1, 5, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 2, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0));
        for (int p = 0; p < 2; p++) begin
            vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 0));
            vecs.push_back(mk(0, 1, 0, 0, 0, 2, 0, 1, 0));
            vecs.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 0));
            vecs.push_back(mk(0, 1, 0, 0, 0, 4, 0, 0, 0));
            vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0));
        end

        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].ld,
                 int'(vecs[i].val), int'(vecs[i].exp_cnt), vecs[i].exp_tick,
                 vecs[i].exp_clk, vecs[i].exp_busy);

        // Mid-period change: get N=8 running from a fresh reset
        step("mid_rst", 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step("mid_ld8", 0, 1, 0, 1, 8, 1, 0, 1, 1);
        step("mid_c2", 0, 1, 0, 0, 0, 2, 0, 1, 1);
        step("mid_c3", 0, 1, 0, 0, 0, 3, 0, 0, 1);
        step("mid_c4", 0, 1, 0, 0, 0, 4, 0, 0, 1);
        step("mid_c5", 0, 1, 0, 0, 0, 5, 0, 0, 1);
        step("mid_wrap6", 0, 1, 0, 0, 0, 0, 1, 1, 0);
        step("n8_c1", 0, 1, 0, 0, 0, 1, 0, 1, 0);
        step("n8_c2", 0, 1, 0, 0, 0, 2, 0, 1, 0);
        step("n8_c3", 0, 1, 0, 0, 0, 3, 0, 1, 0);
        step("n8_ld3", 0, 1, 0, 1, 3, 4, 0, 0, 1);
        step("n8_c5", 0, 1, 0, 0, 0, 5, 0, 0, 1);
        step("n8_c6", 0, 1, 0, 0, 0, 6, 0, 0, 1);
        step("n8_c7", 0, 1, 0, 0, 0, 7, 0, 0, 1);
        step("wrap_ld2", 0, 1, 0, 1, 2, 0, 1, 1, 1);
        step("n3_c1", 0, 1, 0, 0, 0, 1, 0, 1, 1);
        step("n3_c2", 0, 1, 0, 0, 0, 2, 0, 0, 1);
        step("n3_wrap", 0, 1, 0, 0, 0, 0, 1, 1, 0);
        step("n2_c1", 0, 1, 0, 0, 0, 1, 0, 0, 0);
        step("n2_wrap", 0, 1, 0, 0, 0, 0, 1, 1, 0);

        // Enable gating: switch to N=6, stall at count 2, load 7 in the gap
        step("g_ld6", 0, 1, 0, 1, 6, 1, 0, 0, 1);
        step("g_wrap", 0, 1, 0, 0, 0, 0, 1, 1, 0);
        step("g_c1", 0, 1, 0, 0, 0, 1, 0, 1, 0);
        step("g_c2", 0, 1, 0, 0, 0, 2, 0, 1, 0);
        step("gap_ld7", 0, 0, 0, 1, 7, 2, 0, 1, 1);
        for (int i = 1; i < 10; i++)
            step($sformatf("gap%0d", i), 0, 0, 0, 0, 0, 2, 0, 1, 1);
        step("g_c3", 0, 1, 0, 0, 0, 3, 0, 0, 1);
        step("g_c4", 0, 1, 0, 0, 0, 4, 0, 0, 1);
        step("g_c5", 0, 1, 0, 0, 0, 5, 0, 0, 1);
        step("g_wrap7", 0, 1, 0, 0, 0, 0, 1, 1, 0);

        // sync_clr with pending 2 at count 5 (N=7: counts 0-3 high)
        step("n7_c1", 0, 1, 0, 0, 0, 1, 0, 1, 0);
        step("n7_c2", 0, 1, 0, 0, 0, 2, 0, 1, 0);
        step("n7_c3", 0, 1, 0, 0, 0, 3, 0, 1, 0);
        step("n7_c4", 0, 1, 0, 0, 0, 4, 0, 0, 0);
        step("n7_ld2", 0, 1, 0, 1, 2, 5, 0, 0, 1);
        step("sclr", 0, 1, 1, 0, 0, 0, 0, 1, 0);
        step("sclr_n2_c1", 0, 1, 0, 0, 0, 1, 0, 0, 0);
        step("sclr_n2_wrap", 0, 1, 0, 0, 0, 0, 1, 1, 0);

        // Zero load becomes N=1: tick on every enabled cycle
        step("ld0", 0, 1, 0, 1, 0, 1, 0, 0, 1);
        step("ld0_wrap", 0, 1, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++)
            step($sformatf("n1_%0d", i), 0, 1, 0, 0, 0, 0, 1, 1, 0);
        step("n1_hold", 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Reset discards a pending ratio and restores N=6
        step("pre_rst_ld3", 0, 1, 0, 1, 3, 0, 1, 1, 1);
        step("rst_mid", 1, 1, 0, 0, 0, 0, 0, 1, 0);
        step("r_c1", 0, 1, 0, 0, 0, 1, 0, 1, 0);
        step("r_c2", 0, 1, 0, 0, 0, 2, 0, 1, 0);
        step("r_c3", 0, 1, 0, 0, 0, 3, 0, 0, 0);
        step("r_c4", 0, 1, 0, 0, 0, 4, 0, 0, 0);
        step("r_c5", 0, 1, 0, 0, 0, 5, 0, 0, 0);
        step("r_wrap6", 0, 1, 0, 0, 0, 0, 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
